// File: rtl/decoder_3x8_pipe.sv
// Purpose: registered 3-to-8 one-hot decoder feeding a 2-entry output FIFO; optional hit counter (DECODER_HIT_CNT_EN).
// Latency: a code pushed into an empty buffer is on out_d with out_valid=1 right after the push edge.
// Backpressure: in_ready drops when both entries are held; it depends only on registered state, never on out_ready.
module decoder_3x8_pipe #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_code,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_d,
    output logic [CNT_W-1:0] hit_cnt
);

    // Occupancy-tracking states; the encoding equals the entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state_q;
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [7:0]  entry_q [2];
    logic [7:0]  word_d;
    logic        push;
    logic        pop;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // The word is decoded once at push time and stored; it is never recomputed.
    assign word_d = in_en ? (8'b1 << in_code) : 8'h00;

    // Head of the buffer; forced to zero when nothing is held so stale data never leaks out.
    assign out_d = (state_q == EMPTY) ? 8'h00 : entry_q[rd_ptr_q];

    // Buffer storage, pointers and occupancy state move together on push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            entry_q[0] <= 8'h00;
            entry_q[1] <= 8'h00;
        end else begin
            if (push) begin
                entry_q[wr_ptr_q] <= word_d;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case (state_q)
                EMPTY: if (push) state_q <= ONE;
                ONE: begin
                    if (push && !pop)      state_q <= FULL;
                    else if (pop && !push) state_q <= EMPTY;
                end
                FULL:  if (pop) state_q <= ONE;
                default: state_q <= EMPTY;
            endcase
        end
    end

`ifdef DECODER_HIT_CNT_EN
    logic [CNT_W-1:0] hit_cnt_q;

    // Count delivered non-zero words, holding at the maximum instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q <= '0;
        end else if (pop && (out_d != 8'h00) && (hit_cnt_q != {CNT_W{1'b1}})) begin
            hit_cnt_q <= hit_cnt_q + CNT_W'(1);
        end
    end

    assign hit_cnt = hit_cnt_q;
`else
    assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_decoder_3x8_pipe.sv
// Directed bench for decoder_3x8_pipe: reset, single beat, sweep, backpressure, enable-low, async reset, saturation.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Hit-count expectations follow whether DECODER_HIT_CNT_EN is defined for the build.
module tb_decoder_3x8_pipe;

    localparam int CNT_W = 4;
`ifdef DECODER_HIT_CNT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_code;
    logic             in_en;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_d;
    logic [CNT_W-1:0] hit_cnt;

    int vec_cnt;
    int err_cnt;
    int exp_hits;

    decoder_3x8_pipe #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_en     (in_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .hit_cnt   (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected-counter update for one delivered non-zero word.
    task automatic model_hit();
        if (HIT_EN && exp_hits < (2**CNT_W - 1)) exp_hits++;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_code = 3'd0; in_en = 1'b0; out_ready = 1'b0;
        #12;
        vec_cnt++;
        if (out_valid !== 1'b0 || out_d !== 8'h00 || in_ready !== 1'b1 || hit_cnt !== 4'd0) begin
            err_cnt++;
            $display("FAIL reset: valid=%b d=%h rdy=%b hit=%0d, want valid=0 d=00 rdy=1 hit=0",
                     out_valid, out_d, in_ready, hit_cnt);
        end
        rst = 1'b0;
        exp_hits = 0;
        step();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_code = 3'd5; in_en = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        vec_cnt++;
        if (out_valid !== 1'b1 || out_d !== 8'h20) begin
            err_cnt++;
            $display("FAIL single_beat: valid=%b d=%h, want valid=1 d=20", out_valid, out_d);
        end
        step();
        model_hit();
        vec_cnt++;
        if (out_valid !== 1'b0 || out_d !== 8'h00 || in_ready !== 1'b1 || hit_cnt !== exp_hits[CNT_W-1:0]) begin
            err_cnt++;
            $display("FAIL single_drain: valid=%b d=%h rdy=%b hit=%0d, want valid=0 d=00 rdy=1 hit=%0d",
                     out_valid, out_d, in_ready, hit_cnt, exp_hits);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] exp_word;
        out_ready = 1'b1;
        in_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_code  = 3'(i);
            vec_cnt++;
            if (in_ready !== 1'b1) begin
                err_cnt++;
                $display("FAIL sweep_ready[%0d]: rdy=%b, want 1", i, in_ready);
            end
            step();
            if (i > 0) model_hit();
            exp_word = 8'h01 << i;
            vec_cnt++;
            if (out_valid !== 1'b1 || out_d !== exp_word) begin
                err_cnt++;
                $display("FAIL sweep_word[%0d]: valid=%b d=%h, want valid=1 d=%h", i, out_valid, out_d, exp_word);
            end
        end
        in_valid = 1'b0;
        step();
        model_hit();
        vec_cnt++;
        if (out_valid !== 1'b0 || hit_cnt !== exp_hits[CNT_W-1:0]) begin
            err_cnt++;
            $display("FAIL sweep_drain: valid=%b hit=%0d, want valid=0 hit=%0d", out_valid, hit_cnt, exp_hits);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_en = 1'b1;
        in_valid = 1'b1; in_code = 3'd1;
        step();
        vec_cnt++;
        if (out_d !== 8'h02 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL bp_first: d=%h valid=%b rdy=%b, want d=02 valid=1 rdy=1", out_d, out_valid, in_ready);
        end
        in_code = 3'd2;
        step();
        vec_cnt++;
        if (in_ready !== 1'b0 || out_d !== 8'h02) begin
            err_cnt++;
            $display("FAIL bp_full: rdy=%b d=%h, want rdy=0 d=02", in_ready, out_d);
        end
        in_code = 3'd3;
        step();
        vec_cnt++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_d !== 8'h02) begin
            err_cnt++;
            $display("FAIL bp_stall: rdy=%b valid=%b d=%h, want rdy=0 valid=1 d=02", in_ready, out_valid, out_d);
        end
        // Pop while FULL: code 3 must not enter on this edge.
        out_ready = 1'b1;
        step();
        model_hit();
        vec_cnt++;
        if (out_d !== 8'h04 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL bp_release: d=%h rdy=%b valid=%b, want d=04 rdy=1 valid=1", out_d, in_ready, out_valid);
        end
        step();
        model_hit();
        in_valid = 1'b0;
        vec_cnt++;
        if (out_d !== 8'h08 || out_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL bp_code3: d=%h valid=%b, want d=08 valid=1", out_d, out_valid);
        end
        step();
        model_hit();
        vec_cnt++;
        if (out_valid !== 1'b0 || hit_cnt !== exp_hits[CNT_W-1:0]) begin
            err_cnt++;
            $display("FAIL bp_drain: valid=%b hit=%0d, want valid=0 hit=%0d", out_valid, hit_cnt, exp_hits);
        end
    endtask

    task automatic test_enable_low();
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 3'd7; in_en = 1'b0;
        step();
        in_valid = 1'b0; in_en = 1'b1;
        vec_cnt++;
        if (out_valid !== 1'b1 || out_d !== 8'h00) begin
            err_cnt++;
            $display("FAIL en_low_word: valid=%b d=%h, want valid=1 d=00", out_valid, out_d);
        end
        out_ready = 1'b1;
        step();
        vec_cnt++;
        if (out_valid !== 1'b0 || hit_cnt !== exp_hits[CNT_W-1:0]) begin
            err_cnt++;
            $display("FAIL en_low_hits: valid=%b hit=%0d, want valid=0 hit=%0d", out_valid, hit_cnt, exp_hits);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_en = 1'b1;
        in_valid = 1'b1; in_code = 3'd4;
        step();
        in_code = 3'd6;
        step();
        in_valid = 1'b0;
        vec_cnt++;
        if (in_ready !== 1'b0 || out_d !== 8'h10) begin
            err_cnt++;
            $display("FAIL arst_setup: rdy=%b d=%h, want rdy=0 d=10", in_ready, out_d);
        end
        #2;
        rst = 1'b1;
        #1;
        exp_hits = 0;
        vec_cnt++;
        if (out_valid !== 1'b0 || out_d !== 8'h00 || in_ready !== 1'b1 || hit_cnt !== 4'd0) begin
            err_cnt++;
            $display("FAIL arst_immediate: valid=%b d=%h rdy=%b hit=%0d, want valid=0 d=00 rdy=1 hit=0",
                     out_valid, out_d, in_ready, hit_cnt);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        vec_cnt++;
        if (out_valid !== 1'b0 || out_d !== 8'h00) begin
            err_cnt++;
            $display("FAIL arst_after: valid=%b d=%h, want valid=0 d=00", out_valid, out_d);
        end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1; in_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_code  = 3'(i % 8);
            step();
            if (i > 0) model_hit();
        end
        in_valid = 1'b0;
        step();
        model_hit();
        vec_cnt++;
        if (hit_cnt !== exp_hits[CNT_W-1:0]) begin
            err_cnt++;
            $display("FAIL sat_20: hit=%0d, want %0d", hit_cnt, exp_hits);
        end
        in_valid = 1'b1; in_code = 3'd2;
        step();
        in_valid = 1'b0;
        step();
        model_hit();
        vec_cnt++;
        if (hit_cnt !== exp_hits[CNT_W-1:0]) begin
            err_cnt++;
            $display("FAIL sat_hold: hit=%0d, want %0d", hit_cnt, exp_hits);
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        exp_hits = 0;
        test_reset();
        test_single();
        test_sweep();
        test_backpressure();
        test_enable_low();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
